// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and default constants for the whack-a-mole
//               round sequencer and its tick prescaler.
// Contents    : game_state_t (IDLE=0, SPAWN=1, MOLE_UP=2, GAP=3, OVER=4)
//               C_DEF_* default tick/round constants
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPAWN   = 3'd1,
    MOLE_UP = 3'd2,
    GAP     = 3'd3,
    OVER    = 3'd4
  } game_state_t;

  localparam int C_DEF_CLK_TICK_DIV  = 50_000_000;
  localparam int C_DEF_NUM_HOLES     = 8;
  localparam int C_DEF_ROUND_TICKS   = 60;
  localparam int C_DEF_MOLE_UP_TICKS = 2;
  localparam int C_DEF_GAP_TICKS     = 1;
  localparam int C_DEF_SCORE_WIDTH   = 8;

endpackage : game_pkg
`default_nettype wire

// File: rtl/game_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_tick_gen
// Description : Game-tick prescaler. Counts enabled clk cycles and emits a
//               one-cycle tick when the count equals CLK_TICK_DIV-1.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               i_clear  - synchronous clear of the prescaler count
//               i_en     - count enable (game in a PLAY state)
//               o_tick   - one-cycle game tick
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_gen #(
  parameter int CLK_TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int C_CNT_W = (CLK_TICK_DIV > 2) ? $clog2(CLK_TICK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(CLK_TICK_DIV - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               w_wrap;

  assign w_wrap = (r_cnt == C_LAST);
  // Tick is decoded from the count so it lands exactly CLK_TICK_DIV enabled
  // cycles after the last clear.
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + C_CNT_W'(1);
    end
  end

endmodule : game_tick_gen
`default_nettype wire

// File: rtl/whack_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : whack_game_ctrl
// Description : Whack-a-mole round sequencer. Starts and times a round,
//               spawns one mole at a time at a pseudo-random hole and
//               qualifies debounced presses into hits and misses.
// Ports       : clk            - system clock
//               rst_n          - asynchronous active-low reset
//               i_start        - one-cycle start/restart pulse
//               i_btn_pulse    - one-cycle debounced press per hole
//               i_lfsr_hole    - random hole index, sampled in SPAWN
//               o_mole_mask    - one-hot active mole, or 0
//               o_score_clear  - one-cycle clear to score counter
//               o_score_enable - score counter enable (combinational)
//               o_hit_pulse    - one-cycle valid hit
//               o_miss_count   - wrong-hole presses this round (saturating)
//               o_time_left    - remaining round ticks
//               o_game_over    - high in OVER
//               i_score        - current score (GAME_HIGH_SCORE_EN only)
//               o_high_score   - best score since reset (GAME_HIGH_SCORE_EN)
// Options     : GAME_HIGH_SCORE_EN - adds the score/high_score ports and the
//               high-score register.
// Revision    : 1.0 - initial release
// ============================================================================
module whack_game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_TICK_DIV  = C_DEF_CLK_TICK_DIV,
  parameter int NUM_HOLES     = C_DEF_NUM_HOLES,
  parameter int ROUND_TICKS   = C_DEF_ROUND_TICKS,
  parameter int MOLE_UP_TICKS = C_DEF_MOLE_UP_TICKS,
  parameter int GAP_TICKS     = C_DEF_GAP_TICKS
`ifdef GAME_HIGH_SCORE_EN
  ,
  parameter int WIDTH         = C_DEF_SCORE_WIDTH
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [NUM_HOLES-1:0]         i_btn_pulse,
  input  logic [$clog2(NUM_HOLES)-1:0] i_lfsr_hole,
  output logic [NUM_HOLES-1:0]         o_mole_mask,
  output logic                         o_score_clear,
  output logic                         o_score_enable,
  output logic                         o_hit_pulse,
  output logic [7:0]                   o_miss_count,
  output logic [7:0]                   o_time_left,
  output logic                         o_game_over
`ifdef GAME_HIGH_SCORE_EN
  ,
  input  logic [WIDTH-1:0]             i_score,
  output logic [WIDTH-1:0]             o_high_score
`endif
);

  localparam int C_UP_W  = $clog2(MOLE_UP_TICKS + 1);
  localparam int C_GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [NUM_HOLES-1:0] C_ONE_HOLE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  game_state_t          r_state;
  game_state_t          w_state_nxt;
  logic [NUM_HOLES-1:0] r_mole_mask,  w_mole_mask_nxt;
  logic                 r_score_clear, w_score_clear_nxt;
  logic                 r_hit_pulse,  w_hit_pulse_nxt;
  logic [7:0]           r_miss_count, w_miss_count_nxt;
  logic [7:0]           r_time_left,  w_time_left_nxt;
  logic                 r_game_over,  w_game_over_nxt;
  logic [C_UP_W-1:0]    r_up_cnt,     w_up_cnt_nxt;
  logic [C_GAP_W-1:0]   r_gap_cnt,    w_gap_cnt_nxt;

  logic w_play;
  logic w_tick;
  logic w_tick_clr;
  logic w_hit;
  logic w_miss;
  logic w_last_tick;

  // --------------------------------------------------------------------------
  // Tick prescaler: runs only while a round is in play, restarted on start.
  // --------------------------------------------------------------------------
  game_tick_gen #(
    .CLK_TICK_DIV (CLK_TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_tick_clr),
    .i_en    (w_play),
    .o_tick  (w_tick)
  );

  assign w_play = (r_state == SPAWN) || (r_state == MOLE_UP) || (r_state == GAP);
  assign w_hit  = (r_state == MOLE_UP) && (|(i_btn_pulse & r_mole_mask));
  // A press that includes the mole hole is a hit only, even with other holes.
  assign w_miss = w_play && (|i_btn_pulse) && !w_hit;
  // The round ends on the tick that takes time_left from 1 to 0.
  assign w_last_tick = w_play && w_tick && (r_time_left == 8'd1);

  // --------------------------------------------------------------------------
  // State register and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mole_mask   <= '0;
      r_score_clear <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_miss_count  <= '0;
      r_time_left   <= '0;
      r_game_over   <= 1'b0;
      r_up_cnt      <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_mole_mask   <= w_mole_mask_nxt;
      r_score_clear <= w_score_clear_nxt;
      r_hit_pulse   <= w_hit_pulse_nxt;
      r_miss_count  <= w_miss_count_nxt;
      r_time_left   <= w_time_left_nxt;
      r_game_over   <= w_game_over_nxt;
      r_up_cnt      <= w_up_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_mole_mask_nxt   = r_mole_mask;
    w_score_clear_nxt = 1'b0;
    w_hit_pulse_nxt   = 1'b0;
    w_miss_count_nxt  = r_miss_count;
    w_time_left_nxt   = r_time_left;
    w_game_over_nxt   = r_game_over;
    w_up_cnt_nxt      = r_up_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_tick_clr        = 1'b0;

    if (w_miss && (r_miss_count != 8'hFF)) begin
      w_miss_count_nxt = r_miss_count + 8'd1;
    end

    if (w_play && w_tick) begin
      w_time_left_nxt = r_time_left - 8'd1;
    end

    case (r_state)
      IDLE, OVER: begin
        if (i_start) begin
          w_state_nxt       = SPAWN;
          w_score_clear_nxt = 1'b1;
          w_time_left_nxt   = 8'(ROUND_TICKS);
          w_miss_count_nxt  = '0;
          w_game_over_nxt   = 1'b0;
          w_mole_mask_nxt   = '0;
          w_tick_clr        = 1'b1;
        end
      end

      SPAWN: begin
        w_mole_mask_nxt = C_ONE_HOLE << i_lfsr_hole;
        w_up_cnt_nxt    = C_UP_W'(MOLE_UP_TICKS);
        w_state_nxt     = MOLE_UP;
      end

      MOLE_UP: begin
        if (w_hit) begin
          w_hit_pulse_nxt = 1'b1;
          w_mole_mask_nxt = '0;
          w_gap_cnt_nxt   = C_GAP_W'(GAP_TICKS);
          w_state_nxt     = GAP;
        end else if (w_tick) begin
          // Timeout retires the mole without counting a miss.
          if (r_up_cnt == C_UP_W'(1)) begin
            w_mole_mask_nxt = '0;
            w_gap_cnt_nxt   = C_GAP_W'(GAP_TICKS);
            w_state_nxt     = GAP;
          end else begin
            w_up_cnt_nxt = r_up_cnt - C_UP_W'(1);
          end
        end
      end

      GAP: begin
        if (w_tick) begin
          if (r_gap_cnt == C_GAP_W'(1)) begin
            w_state_nxt = SPAWN;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt - C_GAP_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // End of round overrides any PLAY transition; a hit decoded in the same
    // cycle keeps its hit_pulse.
    if (w_last_tick) begin
      w_state_nxt     = OVER;
      w_mole_mask_nxt = '0;
      w_game_over_nxt = 1'b1;
    end
  end

  assign o_mole_mask    = r_mole_mask;
  assign o_score_clear  = r_score_clear;
  assign o_hit_pulse    = r_hit_pulse;
  assign o_miss_count   = r_miss_count;
  assign o_time_left    = r_time_left;
  assign o_game_over    = r_game_over;
  assign o_score_enable = w_play | r_hit_pulse;

`ifdef GAME_HIGH_SCORE_EN
  // --------------------------------------------------------------------------
  // High score: sampled on the edge that enters OVER, cleared only by reset.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_high_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_score <= '0;
    end else if (w_last_tick && (i_score > r_high_score)) begin
      r_high_score <= i_score;
    end
  end

  assign o_high_score = r_high_score;
`endif

endmodule : whack_game_ctrl
`default_nettype wire

// File: tb/tb_whack_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_whack_game_ctrl
// Description : Self-checking bench for whack_game_ctrl. Directed steps in one
//               initial block; expected miss counts for each hit are queued
//               when the hit press is driven and popped when hit_pulse shows.
// Options     : GAME_HIGH_SCORE_EN - also exercises the high-score register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_whack_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_btn_pulse;
  logic [2:0] i_lfsr_hole;
  logic [7:0] o_mole_mask;
  logic       o_score_clear;
  logic       o_score_enable;
  logic       o_hit_pulse;
  logic [7:0] o_miss_count;
  logic [7:0] o_time_left;
  logic       o_game_over;
`ifdef GAME_HIGH_SCORE_EN
  logic [7:0] i_score;
  logic [7:0] o_high_score;
`endif

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int hit_q[$];

  whack_game_ctrl #(
    .CLK_TICK_DIV  (4),
    .NUM_HOLES     (8),
    .ROUND_TICKS   (20),
    .MOLE_UP_TICKS (3),
    .GAP_TICKS     (1)
`ifdef GAME_HIGH_SCORE_EN
    ,
    .WIDTH         (8)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_btn_pulse    (i_btn_pulse),
    .i_lfsr_hole    (i_lfsr_hole),
    .o_mole_mask    (o_mole_mask),
    .o_score_clear  (o_score_clear),
    .o_score_enable (o_score_enable),
    .o_hit_pulse    (o_hit_pulse),
    .o_miss_count   (o_miss_count),
    .o_time_left    (o_time_left),
    .o_game_over    (o_game_over)
`ifdef GAME_HIGH_SCORE_EN
    ,
    .i_score        (i_score),
    .o_high_score   (o_high_score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic goto_edge(input int e);
    while (edge_n < e) step();
  endtask

  // Scoreboard consumer: every hit_pulse must match a queued hit press.
  always @(negedge clk) begin
    if (o_hit_pulse === 1'b1) begin
      tests++;
      assert (hit_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_hit: observed hit_pulse 1 expected no hit queued");
      end
      if (hit_q.size() != 0) begin
        chk("sb_hit_miss", 32'(o_miss_count), 32'(hit_q.pop_front()));
        chk("sb_hit_mask", 32'(o_mole_mask), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_btn_pulse = '0;
    i_lfsr_hole = 3'd5;
`ifdef GAME_HIGH_SCORE_EN
    i_score     = 8'd7;
`endif
    repeat (3) step();

    // Reset state
    chk("rst_state",   32'(dut.r_state), 32'd0);
    chk("rst_mask",    32'(o_mole_mask), 32'h0);
    chk("rst_clear",   32'(o_score_clear), 32'h0);
    chk("rst_hit",     32'(o_hit_pulse), 32'h0);
    chk("rst_miss",    32'(o_miss_count), 32'h0);
    chk("rst_time",    32'(o_time_left), 32'h0);
    chk("rst_over",    32'(o_game_over), 32'h0);
    chk("rst_enable",  32'(o_score_enable), 32'h0);
`ifdef GAME_HIGH_SCORE_EN
    chk("rst_high",    32'(o_high_score), 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // ---------------- Round 1 ----------------
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    edge_n  = 0;
    chk("start_clear", 32'(o_score_clear), 32'h1);
    chk("start_time",  32'(o_time_left), 32'd20);
    chk("start_state", 32'(dut.r_state), 32'd1);
    chk("start_miss",  32'(o_miss_count), 32'h0);
    step();
    chk("spawn_mask",  32'(o_mole_mask), 32'h20);
    chk("spawn_state", 32'(dut.r_state), 32'd2);
    chk("clear_1cyc",  32'(o_score_clear), 32'h0);

    // Hit on hole 5
    i_btn_pulse = 8'h20;
    hit_q.push_back(0);
    step();
    i_btn_pulse = '0;
    chk("hit_pulse",   32'(o_hit_pulse), 32'h1);
    chk("hit_enable",  32'(o_score_enable), 32'h1);
    chk("hit_mask",    32'(o_mole_mask), 32'h0);
    chk("hit_state",   32'(dut.r_state), 32'd3);
    step();
    chk("hit_1cyc",    32'(o_hit_pulse), 32'h0);
    goto_edge(4);
    chk("gap_spawn",   32'(dut.r_state), 32'd1);
    chk("tick1_time",  32'(o_time_left), 32'd19);
    step();
    chk("mole2_mask",  32'(o_mole_mask), 32'h20);

    // Wrong hole, then mole hole plus wrong hole together
    i_btn_pulse = 8'h01;
    step();
    i_btn_pulse = '0;
    chk("miss_count",  32'(o_miss_count), 32'd1);
    chk("miss_nohit",  32'(o_hit_pulse), 32'h0);
    chk("miss_mask",   32'(o_mole_mask), 32'h20);
    i_btn_pulse = 8'h21;
    i_lfsr_hole = 3'd2;
    hit_q.push_back(1);
    step();
    i_btn_pulse = '0;
    chk("dual_hit",    32'(o_hit_pulse), 32'h1);
    chk("dual_miss",   32'(o_miss_count), 32'd1);
    chk("dual_state",  32'(dut.r_state), 32'd3);
    goto_edge(9);
    chk("mole3_mask",  32'(o_mole_mask), 32'h04);

    // Start while playing is ignored
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("play_start_clear", 32'(o_score_clear), 32'h0);
    chk("play_start_state", 32'(dut.r_state), 32'd2);

    // Mole timeout after 3 ticks, SPAWN one tick later
    goto_edge(19);
    chk("up_before_to", 32'(o_mole_mask), 32'h04);
    step();
    chk("timeout_mask",  32'(o_mole_mask), 32'h0);
    chk("timeout_state", 32'(dut.r_state), 32'd3);
    chk("timeout_nomiss", 32'(o_miss_count), 32'd1);
    goto_edge(23);
    chk("gap_hold",    32'(dut.r_state), 32'd3);
    step();
    chk("gap_to_spawn", 32'(dut.r_state), 32'd1);
    chk("tick6_time",  32'(o_time_left), 32'd14);

    // Hit on the final tick cycle
    goto_edge(79);
    chk("pre_end_time",  32'(o_time_left), 32'd1);
    chk("pre_end_state", 32'(dut.r_state), 32'd2);
    chk("pre_end_mask",  32'(o_mole_mask), 32'h04);
    chk("pre_end_over",  32'(o_game_over), 32'h0);
`ifdef GAME_HIGH_SCORE_EN
    chk("pre_end_high",  32'(o_high_score), 32'h0);
`endif
    i_btn_pulse = 8'h04;
    hit_q.push_back(1);
    step();
    i_btn_pulse = '0;
    chk("end_hit",     32'(o_hit_pulse), 32'h1);
    chk("end_state",   32'(dut.r_state), 32'd4);
    chk("end_over",    32'(o_game_over), 32'h1);
    chk("end_mask",    32'(o_mole_mask), 32'h0);
    chk("end_time",    32'(o_time_left), 32'h0);
    chk("end_enable",  32'(o_score_enable), 32'h1);
`ifdef GAME_HIGH_SCORE_EN
    chk("end_high",    32'(o_high_score), 32'd7);
`endif
    step();
    chk("over_hit",    32'(o_hit_pulse), 32'h0);
    chk("over_enable", 32'(o_score_enable), 32'h0);
    goto_edge(85);
    chk("over_hold",   32'(o_game_over), 32'h1);
    chk("over_time",   32'(o_time_left), 32'h0);

    // ---------------- Round 2 (restart, no presses) ----------------
`ifdef GAME_HIGH_SCORE_EN
    i_score = 8'd3;
`endif
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    edge_n  = 0;
    chk("r2_clear",    32'(o_score_clear), 32'h1);
    chk("r2_time",     32'(o_time_left), 32'd20);
    chk("r2_miss",     32'(o_miss_count), 32'h0);
    chk("r2_over",     32'(o_game_over), 32'h0);
    goto_edge(80);
    chk("r2_end_over", 32'(o_game_over), 32'h1);
    chk("r2_end_time", 32'(o_time_left), 32'h0);
    chk("r2_end_mask", 32'(o_mole_mask), 32'h0);
`ifdef GAME_HIGH_SCORE_EN
    chk("r2_high",     32'(o_high_score), 32'd7);
`endif

    // ---------------- Round 3: reset mid-round ----------------
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    edge_n  = 0;
    step();
    chk("r3_mask",     32'(o_mole_mask), 32'h04);
    i_btn_pulse = 8'h04;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(dut.r_state), 32'd0);
    chk("abort_mask",  32'(o_mole_mask), 32'h0);
    chk("abort_time",  32'(o_time_left), 32'h0);
    chk("abort_enable", 32'(o_score_enable), 32'h0);
`ifdef GAME_HIGH_SCORE_EN
    chk("abort_high",  32'(o_high_score), 32'h0);
`endif
    step();
    i_btn_pulse = '0;
    chk("abort_nohit", 32'(o_hit_pulse), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 32'(dut.r_state), 32'd0);
    chk("post_rst_hit",   32'(o_hit_pulse), 32'h0);

    chk("sb_drained",  32'(hit_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_whack_game_ctrl
`default_nettype wire
